atm_session_sequencer: RTL and testbench
========================================

// Module: atm_session_sequencer
// PURPOSE
//  Shares one ATM core among NUM_REQ terminals. Picks one terminal at a time by round-robin
//  and drives that terminal's PIN/amount/biometric/PIN-change request into the core. Waits for
//  the core's result flags and returns a coded result to the granted terminal. Owns the
//  inactivity timer and drives the core's inactivity_timeout input.
// PARAMETERS
//  NUM_REQ         4    number of terminals (2..8)
//  TIMEOUT_CYCLES  64   cycles in WAIT with no core result before a timeout is forced (>=2)
//  ID_W            2    $clog2(NUM_REQ), width of the terminal index
// PORTS
//  clk                    in   1          single clock, rising edge
//  reset_n                in   1          synchronous, active-low reset
//  req_valid              in   NUM_REQ    terminal i requests a session; held until rsp for i
//  req_pin                in   4*NUM_REQ  PIN per terminal; slice i = [4i+3:4i]
//  req_amount             in   8*NUM_REQ  withdrawal amount per terminal
//  req_bio                in   NUM_REQ    biometric passed, per terminal
//  req_chg                in   NUM_REQ    PIN-change request, per terminal
//  req_new_pin            in   4*NUM_REQ  new PIN per terminal
//  grant                  out  NUM_REQ    one-hot: terminal that owns the core (GRANT/WAIT/TMO)
//  rsp_valid              out  1          one-cycle pulse: session finished
//  rsp_id                 out  ID_W       terminal index for this rsp
//  rsp_code               out  3          result code (see package)
//  atm_pin_input          out  4          to core pin_input
//  atm_amount_input       out  8          to core amount_input
//  atm_biometric_auth     out  1          to core biometric_authenticated
//  atm_change_pin_request out  1          to core change_pin_request
//  atm_new_pin            out  4          to core new_pin
//  atm_inactivity_timeout out  1          to core inactivity_timeout
//  atm_txn_success, atm_txn_error, atm_pin_change_success, atm_account_locked,
//  atm_timeout_error      in   1 each     core result flags
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state=IDLE; rr_ptr=0; timer=0; every output is 0.
//  Reset in the middle of a session drops the session silently, with no rsp.
//  FSM states:
//  - IDLE: if any req_valid, pick the first set bit at or after rr_ptr (wrapping), latch its
//    id, go to GRANT. If no req_valid, stay in IDLE.
//  - GRANT: 1 cycle. Drive atm_* from the latched terminal's request slices, with
//    atm_inactivity_timeout=0. Clear timer. Go to WAIT.
//  - WAIT: keep driving atm_*. Increment timer each cycle.
//    - If any result flag is high, capture the code and go to DONE.
//    - Else if timer==TIMEOUT_CYCLES-1, go to TMO.
//    - A result flag in the same cycle as timer expiry: the result wins.
//  - TMO: atm_inactivity_timeout=1, held until atm_timeout_error or any other flag is seen.
//    Capture the code for that flag and go to DONE. No second timer runs in TMO.
//  - DONE: 1 cycle. rsp_valid=1 with rsp_id and rsp_code. atm_* driven to 0. grant=0.
//    rr_ptr = id+1, wrapping at NUM_REQ. Go to IDLE.
//  Abort: if req_valid[id] falls in GRANT, WAIT or TMO, go to DONE with code ABORT.
//  Result priority when several flags are high together:
//    locked > timeout > pin_changed > error > success.
//  Latency: req_valid -> first atm_* drive = 2 cycles (IDLE, GRANT), measured from idle.
//  Fairness: a terminal waits for at most NUM_REQ-1 sessions before it is served.
//  Request inputs are sampled into registers in IDLE. Changes during a session are ignored,
//    except req_valid (used for abort).
//  grant is registered and matches the state. outputs are glitch-free.
// STRUCTURE
//  Package atm_pkg holds:
//  - state enum {IDLE, GRANT, WAIT, TMO, DONE}
//  - rsp codes: NONE=0, SUCCESS=1, ERROR=2, PIN_CHANGED=3, LOCKED=4, TIMEOUT=5, ABORT=6
//  - PIN_W=4, AMT_W=8
//  Sub-module rr_arbiter (NUM_REQ): request vector and pointer -> one-hot pick plus index.
//    Purely combinational.
//  FSM, timer and core-input register live in atm_session_sequencer.
// TESTING
//  1. T1 only: pin=1010, amt=20, bio=1; core raises txn_success in cycle 3 of WAIT
//     -> rsp_valid 1 cycle, rsp_id=1, rsp_code=1, grant[1] high over GRANT..WAIT only.
//  2. T0..T3 all requesting, each core reply an error -> grant order 0,1,2,3,0.
//     Each rsp_code=2. rr_ptr wraps to 0.
//  3. Core stays silent -> atm_inactivity_timeout rises after 64 WAIT cycles.
//     Core answers timeout_error 2 cycles later -> rsp_code=5.
//  4. Core raises account_locked and txn_error together -> rsp_code=4. atm_* = 0 in DONE.
//  5. T2 drops req_valid during WAIT -> next cycle is DONE with rsp_id=2, rsp_code=6.
//     The next grant goes to T3.
//  6. reset_n=0 for 1 cycle during WAIT -> no rsp. All outputs 0. Next grant starts from T0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session sequencer.
//  - state_e    : session FSM states
//  - rsp_code_e : result code returned to the granted terminal
//  - PIN_W/AMT_W: per-terminal field widths
//  - flags_to_code: maps the core result flags to a result code, highest priority first
package atm_pkg;

    localparam int unsigned PIN_W = 4;
    localparam int unsigned AMT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT,
        TMO,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        RSP_NONE        = 3'd0,
        RSP_SUCCESS     = 3'd1,
        RSP_ERROR       = 3'd2,
        RSP_PIN_CHANGED = 3'd3,
        RSP_LOCKED      = 3'd4,
        RSP_TIMEOUT     = 3'd5,
        RSP_ABORT       = 3'd6
    } rsp_code_e;

    // locked > timeout > pin_changed > error > success
    function automatic rsp_code_e flags_to_code(
        input logic success,
        input logic error,
        input logic pin_changed,
        input logic locked,
        input logic timeout
    );
        rsp_code_e code;
        code = RSP_NONE;
        if (locked)           code = RSP_LOCKED;
        else if (timeout)     code = RSP_TIMEOUT;
        else if (pin_changed) code = RSP_PIN_CHANGED;
        else if (error)       code = RSP_ERROR;
        else if (success)     code = RSP_SUCCESS;
        return code;
    endfunction

endpackage

// File: rtl/atm_session_sequencer_rr_arbiter.sv
// Combinational round-robin picker.
//  req  : request vector, one bit per terminal
//  ptr  : search start index (first candidate)
//  pick : one-hot of the first set request at or after ptr, wrapping
//  idx  : index of pick
//  any  : at least one request is set
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/atm_session_sequencer.sv
// Shares one ATM core among NUM_REQ terminals, one session at a time.
//  clk, reset_n            : clock, synchronous active-low reset
//  req_*                   : per-terminal request (valid held until its rsp)
//  grant                   : one-hot owner of the core during GRANT/WAIT/TMO
//  rsp_valid/rsp_id/rsp_code: one-cycle session result to the granted terminal
//  atm_*  (out)            : request fields and inactivity timeout driven into the core
//  atm_*  (in)             : core result flags
module atm_session_sequencer
    import atm_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ID_W           = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [PIN_W*NUM_REQ-1:0] req_pin,
    input  logic [AMT_W*NUM_REQ-1:0] req_amount,
    input  logic [NUM_REQ-1:0]       req_bio,
    input  logic [NUM_REQ-1:0]       req_chg,
    input  logic [PIN_W*NUM_REQ-1:0] req_new_pin,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2:0]               rsp_code,
    output logic [PIN_W-1:0]         atm_pin_input,
    output logic [AMT_W-1:0]         atm_amount_input,
    output logic                     atm_biometric_auth,
    output logic                     atm_change_pin_request,
    output logic [PIN_W-1:0]         atm_new_pin,
    output logic                     atm_inactivity_timeout,
    input  logic                     atm_txn_success,
    input  logic                     atm_txn_error,
    input  logic                     atm_pin_change_success,
    input  logic                     atm_account_locked,
    input  logic                     atm_timeout_error
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_e              state_q, state_d;
    rsp_code_e           code_d, flag_code;
    logic [ID_W-1:0]     rr_ptr, id_q;
    logic [TIMER_W-1:0]  timer;
    logic [NUM_REQ-1:0]  arb_pick;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;
    logic                req_held;
    logic [PIN_W-1:0]    sel_pin, sel_new_pin;
    logic [AMT_W-1:0]    sel_amount;
    logic                sel_bio, sel_chg;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (arb_pick),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    assign req_held  = req_valid[id_q];
    assign flag_code = flags_to_code(atm_txn_success, atm_txn_error, atm_pin_change_success,
                                     atm_account_locked, atm_timeout_error);

    always_comb begin
        sel_pin     = '0;
        sel_amount  = '0;
        sel_bio     = 1'b0;
        sel_chg     = 1'b0;
        sel_new_pin = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_pick[i]) begin
                sel_pin     = req_pin[i*PIN_W +: PIN_W];
                sel_amount  = req_amount[i*AMT_W +: AMT_W];
                sel_bio     = req_bio[i];
                sel_chg     = req_chg[i];
                sel_new_pin = req_new_pin[i*PIN_W +: PIN_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = RSP_NONE;
        unique case (state_q)
            IDLE: begin
                if (arb_any) state_d = GRANT;
            end
            GRANT: begin
                if (!req_held) begin
                    state_d = DONE;
                    code_d  = RSP_ABORT;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_d = DONE;
                    code_d  = RSP_ABORT;
                end else if (flag_code != RSP_NONE) begin
                    state_d = DONE;
                    code_d  = flag_code;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = TMO;
                end
            end
            TMO: begin
                if (!req_held) begin
                    state_d = DONE;
                    code_d  = RSP_ABORT;
                end else if (flag_code != RSP_NONE) begin
                    state_d = DONE;
                    code_d  = flag_code;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Outputs are registered from the next-state decision so they line up with
    // the state they belong to: the request is captured straight into the core
    // input registers on the IDLE->GRANT edge and cleared on entry to DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr                 <= '0;
            id_q                   <= '0;
            timer                  <= '0;
            grant                  <= '0;
            rsp_valid              <= 1'b0;
            rsp_id                 <= '0;
            rsp_code               <= '0;
            atm_pin_input          <= '0;
            atm_amount_input       <= '0;
            atm_biometric_auth     <= 1'b0;
            atm_change_pin_request <= 1'b0;
            atm_new_pin            <= '0;
            atm_inactivity_timeout <= 1'b0;
        end else begin
            if (state_q == WAIT) timer <= timer + TIMER_W'(1);
            else                 timer <= '0;

            if (state_q == IDLE && arb_any) begin
                id_q                   <= arb_idx;
                grant                  <= arb_pick;
                atm_pin_input          <= sel_pin;
                atm_amount_input       <= sel_amount;
                atm_biometric_auth     <= sel_bio;
                atm_change_pin_request <= sel_chg;
                atm_new_pin            <= sel_new_pin;
            end else if (state_d == DONE) begin
                grant                  <= '0;
                atm_pin_input          <= '0;
                atm_amount_input       <= '0;
                atm_biometric_auth     <= 1'b0;
                atm_change_pin_request <= 1'b0;
                atm_new_pin            <= '0;
            end

            atm_inactivity_timeout <= (state_d == TMO);
            rsp_valid              <= (state_d == DONE);
            rsp_id                 <= (state_d == DONE) ? id_q : '0;
            rsp_code               <= (state_d == DONE) ? code_d : RSP_NONE;

            if (state_q == DONE)
                rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
    end

endmodule

// File: tb/tb_atm_session_sequencer.sv
// Self-checking bench for atm_session_sequencer: directed scenarios plus a
// randomized session loop checked against a round-robin / priority model.
module tb_atm_session_sequencer;

    localparam int unsigned N       = 4;
    localparam int unsigned TMO_CYC = 64;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [4*N-1:0] req_pin = '0;
    logic [8*N-1:0] req_amount = '0;
    logic [N-1:0]   req_bio = '0;
    logic [N-1:0]   req_chg = '0;
    logic [4*N-1:0] req_new_pin = '0;
    logic           core_success = 1'b0, core_error = 1'b0, core_pin_chg = 1'b0;
    logic           core_locked = 1'b0, core_timeout = 1'b0;

    logic [N-1:0]   grant;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [2:0]     rsp_code;
    logic [3:0]     atm_pin_input, atm_new_pin;
    logic [7:0]     atm_amount_input;
    logic           atm_biometric_auth, atm_change_pin_request, atm_inactivity_timeout;
    logic [17:0]    drive;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned model_ptr  = 0;

    logic [3:0] t_pin[N];
    logic [3:0] t_new_pin[N];
    logic [7:0] t_amt[N];
    logic       t_bio[N];
    logic       t_chg[N];

    assign drive = {atm_pin_input, atm_amount_input, atm_biometric_auth,
                    atm_change_pin_request, atm_new_pin};

    always #5 clk = ~clk;

    atm_session_sequencer #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO_CYC),
        .ID_W           (2)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .req_valid              (req_valid),
        .req_pin                (req_pin),
        .req_amount             (req_amount),
        .req_bio                (req_bio),
        .req_chg                (req_chg),
        .req_new_pin            (req_new_pin),
        .grant                  (grant),
        .rsp_valid              (rsp_valid),
        .rsp_id                 (rsp_id),
        .rsp_code               (rsp_code),
        .atm_pin_input          (atm_pin_input),
        .atm_amount_input       (atm_amount_input),
        .atm_biometric_auth     (atm_biometric_auth),
        .atm_change_pin_request (atm_change_pin_request),
        .atm_new_pin            (atm_new_pin),
        .atm_inactivity_timeout (atm_inactivity_timeout),
        .atm_txn_success        (core_success),
        .atm_txn_error          (core_error),
        .atm_pin_change_success (core_pin_chg),
        .atm_account_locked     (core_locked),
        .atm_timeout_error      (core_timeout)
    );

    // ---------------- reference model ----------------
    function automatic int unsigned model_pick(input logic [N-1:0] mask);
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned j = (model_ptr + k) % N;
            if (mask[j]) return j;
        end
        return N;
    endfunction

    // f = {locked, timeout, pin_changed, error, success}
    function automatic logic [2:0] model_code(input logic [4:0] f);
        if (f[4]) return 3'd4;
        if (f[3]) return 3'd5;
        if (f[2]) return 3'd3;
        if (f[1]) return 3'd2;
        if (f[0]) return 3'd1;
        return 3'd0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic pack_requests();
        for (int i = 0; i < N; i++) begin
            req_pin[4*i +: 4]     = t_pin[i];
            req_amount[8*i +: 8]  = t_amt[i];
            req_bio[i]            = t_bio[i];
            req_chg[i]            = t_chg[i];
            req_new_pin[4*i +: 4] = t_new_pin[i];
        end
    endtask

    task automatic randomize_terminal(input int unsigned i);
        t_pin[i]     = 4'($urandom);
        t_amt[i]     = 8'($urandom);
        t_bio[i]     = 1'($urandom);
        t_chg[i]     = 1'($urandom);
        t_new_pin[i] = 4'($urandom);
    endtask

    task automatic set_flags(input logic [4:0] f);
        {core_locked, core_timeout, core_pin_chg, core_error, core_success} = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        model_ptr = 0;
    endtask

    // One full session: wait for grant, check core drive, raise flags in WAIT
    // cycle `delay`, check the DONE cycle and the single-cycle rsp pulse.
    task automatic serve(input logic [4:0] flags, input int unsigned delay, input bit perturb,
                         output int unsigned waited, output int unsigned got_id);
        int unsigned  exp_id, n;
        logic [N-1:0] exp_grant;
        logic [17:0]  exp_drive;
        logic [2:0]   exp_code;
        exp_id   = model_pick(req_valid);
        exp_code = model_code(flags);
        waited   = 0;
        got_id   = N;
        n        = 0;
        if (exp_id >= N) begin
            compared++; mismatched++;
            $display("FAIL serve_setup: no terminal requesting, required at least one");
            return;
        end
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 10);
        waited = n;
        if (grant == '0) begin
            compared++; mismatched++;
            $display("FAIL grant_wait: no grant after %0d cycles, required grant to T%0d", n, exp_id);
            return;
        end
        exp_grant         = '0;
        exp_grant[exp_id] = 1'b1;
        exp_drive = {t_pin[exp_id], t_amt[exp_id], t_bio[exp_id], t_chg[exp_id], t_new_pin[exp_id]};
        compared++;
        if (grant !== exp_grant) begin
            mismatched++;
            $display("FAIL grant_onehot: got %b, required %b", grant, exp_grant);
        end
        compared++;
        if (drive !== exp_drive) begin
            mismatched++;
            $display("FAIL grant_drive: got %h, required %h", drive, exp_drive);
        end
        compared++;
        if ({rsp_valid, atm_inactivity_timeout} !== 2'b00) begin
            mismatched++;
            $display("FAIL grant_quiet: rsp_valid/timeout got %b%b, required 00",
                     rsp_valid, atm_inactivity_timeout);
        end
        if (perturb) begin
            t_pin[exp_id] = ~t_pin[exp_id];
            t_amt[exp_id] = t_amt[exp_id] + 8'd1;
            pack_requests();
        end
        for (int unsigned c = 1; c <= delay; c++) begin
            @(negedge clk);
            if (c == delay) begin
                compared++;
                if (grant !== exp_grant || drive !== exp_drive) begin
                    mismatched++;
                    $display("FAIL wait_hold: grant %b drive %h, required %b %h",
                             grant, drive, exp_grant, exp_drive);
                end
                set_flags(flags);
            end
        end
        @(negedge clk);
        got_id = rsp_id;
        compared++;
        if (rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rsp_valid: got %b, required 1", rsp_valid);
        end
        compared++;
        if (rsp_id !== exp_id[1:0]) begin
            mismatched++;
            $display("FAIL rsp_id: got %0d, required %0d", rsp_id, exp_id);
        end
        compared++;
        if (rsp_code !== exp_code) begin
            mismatched++;
            $display("FAIL rsp_code: got %0d, required %0d (flags %b)", rsp_code, exp_code, flags);
        end
        compared++;
        if ({grant, drive, atm_inactivity_timeout} !== '0) begin
            mismatched++;
            $display("FAIL done_outputs: grant %b drive %h tmo %b, required all 0",
                     grant, drive, atm_inactivity_timeout);
        end
        set_flags(5'b0);
        req_valid[exp_id] = 1'b0;
        model_ptr = (exp_id + 1) % N;
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rsp_pulse: rsp_valid got %b after DONE, required 0", rsp_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = '0;
        do_reset();
        compared++;
        if ({grant, rsp_valid, rsp_id, rsp_code, drive, atm_inactivity_timeout} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: grant %b rsp %b/%0d/%0d drive %h tmo %b, required all 0",
                     grant, rsp_valid, rsp_id, rsp_code, drive, atm_inactivity_timeout);
        end
    endtask

    task automatic test_single();
        int unsigned w, id;
        t_pin[1] = 4'b1010; t_amt[1] = 8'd20; t_bio[1] = 1'b1; t_chg[1] = 1'b0; t_new_pin[1] = 4'd0;
        pack_requests();
        req_valid = 4'b0010;
        serve(5'b00001, 3, 1'b0, w, id);
        compared++;
        if (w !== 1) begin
            mismatched++;
            $display("FAIL grant_latency: grant visible after %0d cycles, required 1", w);
        end
    endtask

    task automatic test_round_robin();
        int unsigned w, id;
        int unsigned order[5] = '{0, 1, 2, 3, 0};
        req_valid = '0;
        do_reset();
        for (int unsigned i = 0; i < N; i++) randomize_terminal(i);
        pack_requests();
        req_valid = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            serve(5'b00010, $urandom_range(1, 5), 1'b0, w, id);
            compared++;
            if (id !== order[k]) begin
                mismatched++;
                $display("FAIL rr_order: session %0d went to T%0d, required T%0d", k, id, order[k]);
            end
            if (k < 3) req_valid[id] = 1'b1;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int unsigned exp_id, n;
        randomize_terminal(2);
        pack_requests();
        req_valid = 4'b0100;
        exp_id = model_pick(req_valid);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 10);
        n = 0;
        @(negedge clk);
        while (atm_inactivity_timeout !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        compared++;
        if (n !== TMO_CYC) begin
            mismatched++;
            $display("FAIL timeout_rise: timeout after %0d WAIT cycles, required %0d", n, TMO_CYC);
        end
        compared++;
        if (grant !== 4'b0100) begin
            mismatched++;
            $display("FAIL tmo_grant: got %b, required 0100", grant);
        end
        @(negedge clk);
        compared++;
        if (atm_inactivity_timeout !== 1'b1 || rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL tmo_hold: timeout %b rsp_valid %b, required 1 0",
                     atm_inactivity_timeout, rsp_valid);
        end
        set_flags(5'b01000);
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b1 || rsp_code !== 3'd5 || rsp_id !== exp_id[1:0]) begin
            mismatched++;
            $display("FAIL tmo_rsp: valid %b code %0d id %0d, required 1 5 %0d",
                     rsp_valid, rsp_code, rsp_id, exp_id);
        end
        set_flags(5'b0);
        req_valid = '0;
        model_ptr = (exp_id + 1) % N;
        @(negedge clk);
        compared++;
        if (atm_inactivity_timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL tmo_release: timeout got %b, required 0", atm_inactivity_timeout);
        end
    endtask

    // A result flag in the last WAIT cycle must beat the timeout.
    task automatic test_expiry_race();
        int unsigned w, id;
        randomize_terminal(3);
        pack_requests();
        req_valid = 4'b1000;
        serve(5'b00001, TMO_CYC, 1'b0, w, id);
    endtask

    task automatic test_locked_error();
        int unsigned w, id;
        randomize_terminal(0);
        pack_requests();
        req_valid = 4'b0001;
        serve(5'b10010, 2, 1'b0, w, id);
    endtask

    task automatic test_abort();
        int unsigned w, id, n;
        req_valid = '0;
        do_reset();
        randomize_terminal(2);
        randomize_terminal(3);
        pack_requests();
        req_valid = 4'b1100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 10);
        compared++;
        if (grant !== 4'b0100) begin
            mismatched++;
            $display("FAIL abort_grant: got %b, required 0100", grant);
        end
        @(negedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_code !== 3'd6 || grant !== '0) begin
            mismatched++;
            $display("FAIL abort_rsp: valid %b id %0d code %0d grant %b, required 1 2 6 0000",
                     rsp_valid, rsp_id, rsp_code, grant);
        end
        model_ptr = 3;
        @(negedge clk);
        serve(5'b00100, 2, 1'b0, w, id);
        compared++;
        if (id !== 3) begin
            mismatched++;
            $display("FAIL abort_next: next session went to T%0d, required T3", id);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned w, id, n;
        req_valid = '0;
        do_reset();
        randomize_terminal(1);
        pack_requests();
        req_valid = 4'b0010;
        serve(5'b00001, 1, 1'b0, w, id);
        req_valid = 4'b1000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 10);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        compared++;
        if ({grant, rsp_valid, rsp_id, rsp_code, drive, atm_inactivity_timeout} !== '0) begin
            mismatched++;
            $display("FAIL midreset_outputs: grant %b rsp %b/%0d/%0d drive %h, required all 0",
                     grant, rsp_valid, rsp_id, rsp_code, drive);
        end
        reset_n      = 1'b1;
        model_ptr    = 0;
        req_valid[0] = 1'b1;
        serve(5'b00001, 2, 1'b0, w, id);
        compared++;
        if (id !== 0) begin
            mismatched++;
            $display("FAIL midreset_restart: first grant after reset to T%0d, required T0", id);
        end
        serve(5'b00010, 1, 1'b0, w, id);
    endtask

    task automatic test_random();
        int unsigned w, id;
        for (int unsigned it = 0; it < 40; it++) begin
            for (int unsigned i = 0; i < N; i++)
                if (!req_valid[i]) randomize_terminal(i);
            pack_requests();
            req_valid = req_valid | 4'($urandom_range(0, 15));
            if (req_valid == '0) req_valid[$urandom_range(0, N-1)] = 1'b1;
            serve(5'($urandom_range(1, 31)), $urandom_range(1, 12), 1'($urandom), w, id);
        end
        for (int unsigned k = 0; k < N && req_valid != '0; k++)
            serve(5'b00001, 1, 1'b0, w, id);
    endtask

    initial begin
        for (int unsigned i = 0; i < N; i++) randomize_terminal(i);
        pack_requests();
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_expiry_race();
        test_locked_error();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
